// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the syn_fifo write-port arbiter.
// Holds the arbiter state enum, counter width and pointer wrap helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int STAT_WIDTH = 16;

  // Increment ptr, wrapping from n-1 back to 0.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority search: first set bit of valid_i at or after ptr_i.
// Ports: valid_i request vector, ptr_i start index, idx_o winner, found_o any set.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  function automatic int wrap_add(input int p, input int k);
    int s;
    s = p + k;
    return (s >= N) ? s - N : s;
  endfunction

  logic [W-1:0] j;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'(wrap_add(int'(ptr_i), k));
      if (valid_i[j]) begin
        idx_o   = j;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the syn_fifo write port among
// NUM_REQ valid/ready producers. Zero-latency: the winner's beat is driven
// onto wr_cs/wr_en/data_in in the same cycle it is accepted.
// Ports: clk, rst (async, active-high); req_valid/req_data/req_ready per
// producer; wr_cs, wr_en, data_in, full toward the FIFO; grant_id,
// grant_valid for observation.
// Optional: define FIFO_ARB_STATS_EN to add stat_cnt (per-producer
// accepted-beat counters) and stall_cnt (full-stall cycles), both
// saturating 16-bit.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_cs,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_valid
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0] stat_cnt,
  output logic [STAT_WIDTH-1:0]         stall_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [IW-1:0] gid_q, gid_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          xfer;
  logic [IW-1:0] win;
  logic          go;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return IW'(rr_next(int'(p), NUM_REQ));
  endfunction

  rr_pick #(
    .N (NUM_REQ),
    .W (IW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Next state. full freezes everything, including a locked owner
  // whose valid has dropped: stalling never releases ownership.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    xfer     = 1'b0;
    win      = owner_q;
    gid_d    = (state_q == LOCKED) ? owner_q : gid_q;
    if (!full) begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            xfer  = 1'b1;
            win   = pick_idx;
            gid_d = pick_idx;
            if (MAX_BURST > 1) begin
              state_d = LOCKED;
              owner_d = pick_idx;
              burst_d = BW'(1);
            end else begin
              rr_ptr_d = nxt(pick_idx);
            end
          end
        end
        LOCKED: begin
          if (req_valid[owner_q]) begin
            xfer = 1'b1;
            if (burst_q == BW'(MAX_BURST - 1)) begin
              state_d  = IDLE;
              rr_ptr_d = nxt(owner_q);
            end else begin
              burst_d = burst_q + 1'b1;
            end
          end else begin
            // Owner went quiet: one bubble, then rotate past it.
            state_d  = IDLE;
            rr_ptr_d = nxt(owner_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reset masks every output combinationally, not just the state.
  assign go          = xfer & ~rst;
  assign wr_cs       = go;
  assign wr_en       = go;
  assign grant_valid = go;
  assign grant_id    = rst ? '0 : gid_d;

  always_comb begin
    req_ready = '0;
    data_in   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (go && win == IW'(i)) begin
        req_ready[i] = 1'b1;
        data_in      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      gid_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      gid_q    <= gid_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [NUM_REQ];
  logic [STAT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && stat_q[i] != '1) begin
          stat_q[i] <= stat_q[i] + 1'b1;
        end
      end
      if (|req_valid && full && stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign stat_cnt[i*STAT_WIDTH +: STAT_WIDTH] = stat_q[i];
  end
  assign stall_cnt = stall_q;
`endif

  // Producers must hold valid and data steady until accepted.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (rst)
      req_valid[i] && !req_ready[i] |=>
        req_valid[i] &&
        $stable(req_data[i*DATA_WIDTH +: DATA_WIDTH]));
  end

endmodule
